spi_log_packer: RTL and testbench

Buffers SPI flash read-log events (address and length from the flash emulator's log interface) in a small event FIFO and serializes each event into a fixed-length byte record for the serial transmit path. It sits between the flash emulator's log strobe outputs and the serial TX FIFO/uart. Bursts of back-to-back flash reads are absorbed without losing records while the serial link drains, and losses are counted when the buffer overflows.

---
 rtl/spi_log_pkg.sv | 35 +++
 rtl/log_fifo.sv | 63 ++++++
 rtl/spi_log_packer.sv | 135 +++++++++++++
 tb/tb_spi_log_packer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_log_pkg.sv
// Shared definitions for the SPI flash read-log packer.
// Build option: SPI_LOG_MAGIC_EN prefixes every record with ASCII "READ".
package spi_log_pkg;

  localparam int          REC_BYTES_PLAIN = 4;
  localparam int          REC_BYTES_MAGIC = 8;
  localparam logic [31:0] MAGIC           = 32'h52454144;

`ifdef SPI_LOG_MAGIC_EN
  localparam int REC_BYTES = REC_BYTES_MAGIC;
`else
  localparam int REC_BYTES = REC_BYTES_PLAIN;
`endif

  // One buffered log event as stored in the event FIFO.
  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  len;
  } log_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Left-justified image of a record; bytes leave from bit 63 downward.
  function automatic logic [63:0] load_record(input log_entry_t e);
`ifdef SPI_LOG_MAGIC_EN
    return {MAGIC, e.addr, e.len};
`else
    return {e.addr, e.len, 32'h0};
`endif
  endfunction

endpackage

// File: rtl/log_fifo.sv
// Single-clock synchronous FIFO with occupancy level.
// Read data is the current head entry (valid whenever empty_o is low).
module log_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Storage write.
  // NOTE: the data array is not reset; its contents are unobservable until written, and leaving it out of reset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and level bookkeeping; pointers wrap naturally modulo DEPTH.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_log_packer.sv
// Buffers flash read-log events and serializes each into a byte record,
// MSB first, with saturating drop counting on FIFO overflow.
// Build option: SPI_LOG_MAGIC_EN (8-byte records prefixed "READ"; else 4 bytes).
module spi_log_packer
  import spi_log_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   log_strobe,
  input  logic [31:0]            log_addr,
  input  logic [7:0]             log_len,
  input  logic                   txd_ready,
  output logic [7:0]             txd,
  output logic                   txd_strobe,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  localparam logic [2:0] LAST_IDX = 3'(REC_BYTES - 1);

  ser_state_e        state_q, state_d;
  logic [63:0]       shift_q, shift_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        txd_q, txd_d;
  logic              strobe_q, strobe_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              overflow_q, overflow_d;

  log_entry_t        wr_entry;
  log_entry_t        head;
  logic [31:0]       head_raw;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              accept;
  logic              drop;

  // Upper address bits are outside the emulated flash window.
  logic unused_addr;
  assign unused_addr = &{1'b0, log_addr[31:24]};

  assign wr_entry = '{addr: log_addr[23:0], len: log_len};
  assign head     = log_entry_t'(head_raw);

  // A full FIFO still accepts when the serializer pops in the same cycle.
  assign accept = log_strobe && (!fifo_full || pop);
  assign drop   = log_strobe && !accept;

  log_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (accept),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Serializer next-state, byte output and drop accounting.
  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    txd_d      = txd_q;
    strobe_d   = 1'b0;
    pop        = 1'b0;
    drop_d     = drop_q;
    overflow_d = overflow_q | drop;

    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = load_record(head);
          cnt_d   = LAST_IDX;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (txd_ready) begin
          strobe_d = 1'b1;
          txd_d    = shift_q[63:56];
          shift_d  = {shift_q[55:0], 8'h00};
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Serializer, output and drop-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      txd_q      <= '0;
      strobe_q   <= 1'b0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      txd_q      <= txd_d;
      strobe_q   <= strobe_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  assign txd        = txd_q;
  assign txd_strobe = strobe_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_spi_log_packer.sv
// Scoreboard bench for spi_log_packer: stimulus pushes expected record
// bytes into a queue, a negedge monitor pops and compares on every strobe.
module tb_spi_log_packer;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 8;
`ifdef SPI_LOG_MAGIC_EN
  localparam int TB_REC = 8;
`else
  localparam int TB_REC = 4;
`endif

  logic              clk        = 1'b0;
  logic              reset      = 1'b0;
  logic              log_strobe = 1'b0;
  logic [31:0]       log_addr   = '0;
  logic [7:0]        log_len    = '0;
  logic              txd_ready  = 1'b0;
  logic [7:0]        txd;
  logic              txd_strobe;
  logic [4:0]        fifo_level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  int         checks     = 0;
  int         errors     = 0;
  int         bytes_seen = 0;
  logic [7:0] exp_q [$];
  logic       ready_prev = 1'b0;

  spi_log_packer #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .log_strobe (log_strobe),
    .log_addr   (log_addr),
    .log_len    (log_len),
    .txd_ready  (txd_ready),
    .txd        (txd),
    .txd_strobe (txd_strobe),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Ready as the DUT sampled it on the most recent edge.
  always @(posedge clk) ready_prev <= txd_ready;

  // Monitor: every strobe must follow a high-ready sample and match the queue head.
  always @(negedge clk) begin
    if (reset && txd_strobe) begin
      bytes_seen++;
      check("strobe_follows_ready", {31'h0, ready_prev}, 32'h1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got byte 0x%0h, expected no strobe", txd);
      end else begin
        check("txd_byte", {24'h0, txd}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_expected(input logic [31:0] a, input logic [7:0] l);
`ifdef SPI_LOG_MAGIC_EN
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h44);
`endif
    exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(l);
  endtask

  // Called at posedge+2; holds log_strobe high across exactly one edge.
  task automatic drive_event(input logic [31:0] a, input logic [7:0] l, input bit accepted);
    log_strobe = 1'b1;
    log_addr   = a;
    log_len    = l;
    if (accepted) push_expected(a, l);
    @(posedge clk);
    #2;
    log_strobe = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) step(1);
    if (exp_q.size() != 0) check(name, exp_q.size(), 0);
    step(2);
  endtask

  initial begin : stim
    int base;
    bit hit;

    // Reset state while reset is held low.
    #12;
    check("rst_txd",        {24'h0, txd},        32'h0);
    check("rst_strobe",     {31'h0, txd_strobe}, 32'h0);
    check("rst_level",      {27'h0, fifo_level}, 32'h0);
    check("rst_overflow",   {31'h0, overflow},   32'h0);
    check("rst_drop_count", {24'h0, drop_count}, 32'h0);
    reset = 1'b1;
    step(1);

    // Single event with ready high: entry after edge 0, first strobe after edge 2.
    txd_ready = 1'b1;
    drive_event(32'h0012_3456, 8'h40, 1'b1);
    @(negedge clk);
    check("single_level_after_push", {27'h0, fifo_level}, 32'h1);
    @(negedge clk);
    check("single_no_early_strobe", {31'h0, txd_strobe}, 32'h0);
    @(negedge clk);
    check("single_first_strobe", {31'h0, txd_strobe}, 32'h1);
    @(posedge clk);
    #2;
    drain("single_drain_timeout");

    // Backpressure: two records (upper address byte ignored), ready 1,0,0,1,...
    drive_event(32'h00AB_CDEF, 8'h07, 1'b1);
    drive_event(32'hFF00_00FF, 8'hC3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      txd_ready = ((i % 4) == 0) || ((i % 4) == 3);
      step(1);
    end
    txd_ready = 1'b1;
    drain("backpressure_drain_timeout");

    // Overflow: stall a blocker record in SEND, then 20 back-to-back events.
    txd_ready = 1'b0;
    drive_event(32'h0011_1111, 8'h01, 1'b1);
    step(2);
    for (int i = 0; i < 20; i++) begin
      drive_event({8'h5A, 8'h20, 8'(i), 8'(i * 3)}, 8'(8'h80 + i), i < 16);
    end
    check("ovf_level",      {27'h0, fifo_level}, 32'd16);
    check("ovf_drop_count", {24'h0, drop_count}, 32'd4);
    check("ovf_flag",       {31'h0, overflow},   32'h1);

    // Full FIFO: event in the same cycle as the IDLE pop after the blocker finishes.
    txd_ready = 1'b1;
    step(TB_REC);
    drive_event(32'h0077_8899, 8'hAA, 1'b1);
    check("full_pop_level",      {27'h0, fifo_level}, 32'd16);
    check("full_pop_drop_count", {24'h0, drop_count}, 32'd4);
    drain("overflow_drain_timeout");
    check("ovf_level_drained", {27'h0, fifo_level}, 32'h0);
    check("ovf_flag_sticky",   {31'h0, overflow},   32'h1);

    // Saturation: 16 accepted, 300 more dropped on top of the earlier 4.
    txd_ready = 1'b0;
    drive_event(32'h0011_1111, 8'h01, 1'b1);
    step(2);
    for (int i = 0; i < 316; i++) begin
      drive_event({8'h00, 8'h33, 8'(i), 8'h0F}, 8'(i), i < 16);
    end
    check("sat_drop_count", {24'h0, drop_count}, 32'hFF);
    check("sat_level",      {27'h0, fifo_level}, 32'd16);

    // Reset after the second byte of the stalled blocker.
    base = bytes_seen;
    hit  = 1'b0;
    txd_ready = 1'b1;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (bytes_seen - base >= 2) hit = 1'b1;
    end
    check("mid_record_two_bytes", bytes_seen - base, 2);
    reset = 1'b0;
    #1;
    check("mid_rst_txd",        {24'h0, txd},        32'h0);
    check("mid_rst_strobe",     {31'h0, txd_strobe}, 32'h0);
    check("mid_rst_level",      {27'h0, fifo_level}, 32'h0);
    check("mid_rst_overflow",   {31'h0, overflow},   32'h0);
    check("mid_rst_drop_count", {24'h0, drop_count}, 32'h0);
    exp_q.delete();
    step(2);
    reset = 1'b1;
    base = bytes_seen;
    step(10);
    check("post_rst_no_strobes", bytes_seen - base, 0);
    drive_event(32'h00C0_FFEE, 8'h99, 1'b1);
    drain("post_rst_drain_timeout");
    check("post_rst_record_len", bytes_seen - base, TB_REC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
